// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one byte to a PS/2 device. The host holds the clock low for
// INHIBIT_CYCLES, drives the start bit, releases the clock and then lets
// the device clock out data, parity and stop. The device's ack bit is
// read on the 11th falling edge.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles ps2_clk is held low before the start bit
//   TIMEOUT_CYCLES  max clk cycles from clock release to the ack sample
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   tx_valid, tx_data[7:0]      command byte offer
//   tx_ready                    high only when idle (byte accepted on valid&ready)
//   ps2_clk_in, ps2_data_in     raw bus levels
//   ps2_clk_oe, ps2_data_oe     1 = pull the line low, 0 = release
//   done, err                   single-cycle result pulses
//   busy                        high whenever not idle
//
// Optional feature: define PS2_TX_RETRY_EN to re-send the byte once
// after a NACK or timeout before reporting err.

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       done,
   output logic       err,
   output logic       busy
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, INHIBIT, REQ, SHIFT} state_t;

   state_t        state, state_d;
   logic [2:0]    clk_sync, data_sync;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] to_cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    frame;     // {stop, parity, data} as accepted
   logic [9:0]    shreg;     // working copy, shifted LSB first
   logic          drive;     // registered data_oe during SHIFT

   logic fall, accept, inh_last, active, ack_edge, timeout, ok, fail, retry_now;

   // Sync chain: [0] newest, [2] oldest; falling edge is old 1 -> new 0.
   assign fall     = clk_sync[2] & ~clk_sync[1];
   assign accept   = tx_valid & (state == IDLE);
   assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
   assign active   = (state == REQ) || (state == SHIFT);
   assign ack_edge = (state == SHIFT) && fall && (bit_cnt == 4'd10);
   // An ack edge arriving on the timeout cycle still counts as in time.
   assign timeout  = active && (to_cnt == TW'(TIMEOUT_CYCLES)) && !ack_edge;
   assign ok       = ack_edge & ~data_sync[2];
   assign fail     = (ack_edge & data_sync[2]) | timeout;

`ifdef PS2_TX_RETRY_EN
   logic retried;
   assign retry_now = fail & ~retried;
   always_ff @(posedge clk) begin
      if (rst)            retried <= 1'b0;
      else if (accept)    retried <= 1'b0;
      else if (retry_now) retried <= 1'b1;
   end
`else
   assign retry_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Result pulses are issued in the last busy cycle so tx_ready rises
   // on the following cycle; they are masked while reset is applied.
   always_comb begin
      state_d     = state;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         IDLE: if (accept) state_d = INHIBIT;
         INHIBIT: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = inh_last;
            if (inh_last) state_d = REQ;
         end
         REQ, SHIFT: begin
            ps2_data_oe = (state == REQ) ? 1'b1 : drive;
            if (ok || fail)              state_d = retry_now ? INHIBIT : IDLE;
            else if (state == REQ && fall) state_d = SHIFT;
            done = ok & ~rst;
            err  = fail & ~retry_now & ~rst;
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         inh_cnt   <= '0;
         to_cnt    <= '0;
         bit_cnt   <= '0;
         frame     <= '0;
         shreg     <= '0;
         drive     <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk_in};
         data_sync <= {data_sync[1:0], ps2_data_in};
         inh_cnt   <= (state == INHIBIT && !inh_last) ? inh_cnt + IW'(1) : '0;
         // Zero on the first REQ cycle, so timeout fires TIMEOUT_CYCLES later.
         to_cnt    <= active ? to_cnt + TW'(1) : '0;
         if (accept) frame <= {1'b1, ~^tx_data, tx_data};
         if (state == INHIBIT) begin
            shreg   <= frame;
            bit_cnt <= '0;
         end else if (active && fall && bit_cnt != 4'd10) begin
            // Edges 1..10 put data, parity, stop on the line (inverted: oe=1 pulls low).
            drive   <= ~shreg[0];
            shreg   <= {1'b0, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int INH = 10;
   localparam int TMO = 2000;

   logic clk = 1'b0, rst = 1'b1;
   logic tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic tx_ready, ps2_clk_oe, ps2_data_oe, done, err, busy;
   logic dev_clk = 1'b1, dev_data = 1'b1;
   logic ps2_clk_in, ps2_data_in;

   // Open-drain bus: either side may pull low.
   assign ps2_clk_in  = ~ps2_clk_oe  & dev_clk;
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .done(done), .err(err), .busy(busy));

   always #5 clk = ~clk;

`ifdef PS2_TX_RETRY_EN
   localparam int RETRY = 1;
`else
   localparam int RETRY = 0;
`endif

   int tests = 0, fails = 0;
   int cyc = 0;
   int n_done = 0, n_err = 0, n_both = 0, n_inh = 0, bad_run = 0, run = 0;
   int late_ready = 0, ready_on_pulse = 0;
   int req_cyc = 0, err_cyc = 0;
   logic prev_clk_oe = 1'b0, prev_pulse = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus/pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) n_done++;
      if (err) begin n_err++; err_cyc = cyc; end
      if (done && err) n_both++;
      if ((done || err) && tx_ready) ready_on_pulse++;
      if (prev_pulse && !tx_ready) late_ready++;
      prev_pulse = done | err;
      if (ps2_clk_oe && !prev_clk_oe) n_inh++;
      if (!ps2_clk_oe && prev_clk_oe && ps2_data_oe) req_cyc = cyc;
      if (ps2_clk_oe) run++;
      else if (run != 0) begin
         if (run != INH) bad_run++;
         run = 0;
      end
      prev_clk_oe = ps2_clk_oe;
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: data LSB first, odd parity, stop=1; oe is the inverse of each bit.
   function automatic logic [9:0] model_oe(input logic [7:0] d);
      logic [9:0] bits;
      for (int i = 0; i < 8; i++) bits[i] = d[i];
      bits[8] = ($countones(d) % 2 == 0);
      bits[9] = 1'b1;
      return ~bits;
   endfunction

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Device: wait for start bit with clock released, then clock nedges edges.
   task automatic run_device(input logic ack, input int nedges, output logic [9:0] seen);
      int w;
      seen = '0;
      w = 0;
      while (!(busy && !ps2_clk_oe && ps2_data_oe) && w < 1000) begin
         @(negedge clk); w++;
      end
      check("req_wait", (w < 1000), 1);
      for (int n = 1; n <= nedges; n++) begin
         if (n == 11) dev_data = ack;
         repeat (50) @(negedge clk);
         dev_clk = 1'b0;
         repeat (40) @(negedge clk);
         if (n <= 10) seen[n-1] = ps2_data_oe;
         repeat (10) @(negedge clk);
         dev_clk = 1'b1;
      end
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
   endtask

   task automatic do_txn(input string name, input logic [7:0] d, input logic ack,
                         input logic [9:0] exp_oe, input int exp_done, input int exp_err,
                         input int exp_inh);
      logic [9:0] seen, seen2;
      int d0, e0, i0;
      d0 = n_done; e0 = n_err; i0 = n_inh;
      send(d);
      run_device(ack, 11, seen);
      if (ack && RETRY != 0) run_device(ack, 11, seen2);
      repeat (5) @(negedge clk);
      check({name, "_oe"}, seen, exp_oe);
      check({name, "_done"}, n_done - d0, exp_done);
      check({name, "_err"}, n_err - e0, exp_err);
      check({name, "_inhibits"}, n_inh - i0, exp_inh);
      check({name, "_idle"}, {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       ack;
      logic [9:0] exp_oe;
      int         exp_done;
      int         exp_err;
      int         exp_inh;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [9:0] seen;
      logic [7:0] rd;
      logic ra;
      int d0, e0, w;

      vecs[0] = '{8'hED, 1'b0, 10'h012, 1, 0, 1};
      vecs[1] = '{8'h01, 1'b0, 10'h1FE, 1, 0, 1};
      vecs[2] = '{8'h00, 1'b0, 10'h0FF, 1, 0, 1};
      vecs[3] = '{8'hFF, 1'b0, 10'h000, 1, 0, 1};
      vecs[4] = '{8'hED, 1'b1, 10'h012, 0, 1, 1 + RETRY};

      repeat (3) @(negedge clk);
      check("reset_outs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);
      // Reset wins over tx_valid in the same cycle.
      tx_valid = 1'b1; tx_data = 8'hAA;
      @(negedge clk);
      check("rst_priority", {tx_ready, busy}, 2'b10);
      tx_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         do_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, vecs[i].exp_oe,
                vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_inh);

      for (int i = 0; i < 6; i++) begin
         rd = 8'($urandom);
         ra = 1'($urandom_range(0, 1));
         do_txn($sformatf("rnd%0d_%02h", i, rd), rd, ra, model_oe(rd),
                ra ? 0 : 1, ra ? 1 : 0, ra ? 1 + RETRY : 1);
      end

      // Device never clocks: err exactly TMO cycles after the REQ phase starts.
      e0 = n_err;
      send(8'h12);
      w = 0;
      while (n_err == e0 && w < 6000) begin @(negedge clk); w++; end
      check("timeout_err", n_err - e0, 1);
      check("timeout_delay", err_cyc - req_cyc, TMO);
      @(negedge clk);
      check("timeout_release", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);

      // Reset after edge 5 aborts silently, then a new byte completes.
      d0 = n_done; e0 = n_err;
      send(8'hF0);
      run_device(1'b0, 5, seen);
      check("abort_partial_oe", seen[4:0], model_oe(8'hF0) & 10'h01F);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_release", {ps2_clk_oe, ps2_data_oe, tx_ready, busy}, 4'b0010);
      repeat (5) @(negedge clk);
      check("abort_no_pulse", {n_done - d0, n_err - e0}, 64'd0);
      do_txn("after_abort", 8'hF4, 1'b0, model_oe(8'hF4), 1, 0, 1);

      // tx_valid held with a new byte during a transfer is ignored.
      d0 = n_done;
      @(negedge clk);
      tx_valid = 1'b1; tx_data = 8'hED;
      @(negedge clk);
      tx_data = 8'h55;
      fork
         run_device(1'b0, 11, seen);
         begin
            w = 0;
            while (!done && w < 3000) begin @(negedge clk); w++; end
            tx_valid = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check("hold_oe", seen, 10'h012);
      check("hold_done", n_done - d0, 1);
      check("hold_idle", {tx_ready, busy}, 2'b10);

      check("never_both", n_both, 0);
      check("ready_low_on_pulse", ready_on_pulse, 0);
      check("ready_after_pulse", late_ready, 0);
      check("inhibit_len", bad_run, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, max clk cycles from clock release to ack sample (15 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, system clock; reset rst, synchronous, active-high.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tx_valid, input, 1, command byte offered.
REQ-006 SHALL have port tx_data, input, 8, command byte (e.g. 0xED set-LEDs).
REQ-007 SHALL have port tx_ready, output, 1, high only in IDLE.
REQ-008 SHALL have ports ps2_clk_in and ps2_data_in, input, 1 each, raw bus levels.
REQ-009 SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each; 1 = drive line low, 0 = release (open drain).
REQ-010 SHALL have ports done and err, output, 1 each, single-cycle result pulses; busy, output, 1, high whenever not IDLE.

Function
REQ-011 SHALL synchronise ps2_clk_in/ps2_data_in through 3 flops and detect a device falling edge as synced 1->0.
REQ-012 SHALL accept a byte when tx_valid & tx_ready, latch tx_data plus odd parity (ones count over data+parity odd), and enter INHIBIT next cycle.
REQ-013 SHALL ignore tx_valid while busy; latched byte is unaffected by later tx_data changes.
REQ-014 INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles; data_oe=1 on the last INHIBIT cycle.
REQ-015 REQ state: clk_oe=0, data_oe=1 (start bit); timeout counter cleared and starts counting.
REQ-016 SHIFT: on falling edges 1-8 data_oe = ~bit[n-1] (LSB first); edge 9 data_oe = ~parity; edge 10 data_oe=0 (stop); bit counter 4 bits.
REQ-017 ACK: on falling edge 11 sample synced data; 0 -> done pulse; 1 -> err pulse; then IDLE with both OEs 0.
REQ-018 If timeout counter reaches TIMEOUT_CYCLES before edge 11, SHALL release both lines, pulse err, return to IDLE.
REQ-019 done and err SHALL never assert in the same cycle; tx_ready rises the cycle after done/err.
REQ-020 Falling edges seen in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-021 On rst: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, err=0, counters 0, synchronisers 1.
REQ-022 rst mid-transfer SHALL release both lines on the next clk edge; no done/err pulse for the aborted byte.
REQ-023 rst SHALL take priority over tx_valid in the same cycle.

Configuration
REQ-024 Macro PS2_TX_RETRY_EN defined: on NACK or timeout, SHALL silently re-run the same byte from INHIBIT once; err only if the retry also fails; done if retry succeeds.
REQ-025 Macro PS2_TX_RETRY_EN undefined: first NACK/timeout pulses err immediately; no retry logic synthesised.

Verification (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000, device model clock period 100 clk)
REQ-026 tx_data=0xED, device acks -> clk_oe high 10 cycles, data_oe sequence per edge 0,1,0,0,1,0,0,0,0 then 0 at edge 10, done pulse once, err 0.
REQ-027 tx_data=0x01 -> parity bit 0 (data_oe=1 at edge 9), done pulse.
REQ-028 device leaves data high at edge 11 -> err pulse (macro off); with PS2_TX_RETRY_EN, second INHIBIT phase observed, then err.
REQ-029 device never clocks -> err exactly 2000 cycles after REQ entry, both OEs 0.
REQ-030 rst asserted after edge 5 -> OEs 0 next cycle, no done/err, tx_ready=1; new tx_valid=0xF4 then completes with done.
REQ-031 tx_valid held with 0x55 during a 0xED transfer -> only 0xED transmitted, one done.
